// File: rtl/drr_mixer.sv
// drr_mixer: frame-atomic deficit-round-robin arbiter that feeds one egress
// FIFO from four PHY ingress FIFOs and the NIC FIFO.
module drr_mixer #(
   parameter logic [1:0]  Port       = 2'h0,
   parameter logic [1:0]  MaxPort    = 2'h3,
   parameter logic [13:0] Quantum    = 14'd1518,
   parameter logic [13:0] NicQuantum = 14'd1518
) (
   input  logic       sys_clk,
   input  logic       sys_rst,
   input  logic [8:0] port0_dout,
   input  logic [8:0] port1_dout,
   input  logic [8:0] port2_dout,
   input  logic [8:0] port3_dout,
   input  logic [8:0] nic_dout,
   input  logic       port0_empty,
   input  logic       port1_empty,
   input  logic       port2_empty,
   input  logic       port3_empty,
   input  logic       nic_empty,
   output logic       port0_rd_en,
   output logic       port1_rd_en,
   output logic       port2_rd_en,
   output logic       port3_rd_en,
   output logic       nic_rd_en,
   output logic [8:0] din,
   input  logic       full,
   output logic       wr_en,
   output logic [2:0] grant,
   output logic       busy
);
   localparam logic [2:0]  None   = 3'd7;
   localparam logic [14:0] DefMin = 15'h4000;

   typedef enum logic {IDLE, XFER} state_t;

   state_t           state;
   logic [2:0]       last_grant;
   logic [2:0]       pick;
   logic [4:0][14:0] deficit;
   logic [4:0]       empty_v;
   logic [4:0]       enabled;
   logic [4:0]       eligible;
   logic             g_empty;

   assign empty_v = {nic_empty, port3_empty, port2_empty,
                     port1_empty, port0_empty};

   // Add one quantum, never exceeding +quantum.
   function automatic logic [14:0] refill(input logic [14:0] d,
                                          input logic [13:0] q);
      logic signed [15:0] s;
      s = $signed({d[14], d}) + $signed({2'b00, q});
      refill = (s > $signed({2'b00, q})) ? {1'b0, q} : s[14:0];
   endfunction

   always_comb begin
      enabled = 5'b10000;
      for (int i = 0; i < 4; i++)
         enabled[i] = (2'(i) != Port) && (2'(i) <= MaxPort);
   end

   always_comb begin
      for (int i = 0; i < 5; i++)
         eligible[i] = enabled[i] && !empty_v[i] &&
                       !deficit[i][14] && (deficit[i] != '0);
   end

   // Scan far-to-near so the source nearest last_grant+1 wins.
   always_comb begin
      logic [2:0] j;
      pick = None;
      j    = '0;
      for (int k = 5; k >= 1; k--) begin
         j = 3'((int'(last_grant) + k) % 5);
         if (eligible[j]) pick = j;
      end
   end

   always_comb begin
      g_empty = 1'b1;
      din     = port0_dout;
      case (grant)
         3'd0: begin g_empty = port0_empty; din = port0_dout; end
         3'd1: begin g_empty = port1_empty; din = port1_dout; end
         3'd2: begin g_empty = port2_empty; din = port2_dout; end
         3'd3: begin g_empty = port3_empty; din = port3_dout; end
         3'd4: begin g_empty = nic_empty;   din = nic_dout;   end
         default: ;
      endcase
   end

   assign wr_en       = (state == XFER) && !g_empty && !full;
   assign port0_rd_en = wr_en && (grant == 3'd0);
   assign port1_rd_en = wr_en && (grant == 3'd1);
   assign port2_rd_en = wr_en && (grant == 3'd2);
   assign port3_rd_en = wr_en && (grant == 3'd3);
   assign nic_rd_en   = wr_en && (grant == 3'd4);

   always_ff @(posedge sys_clk or posedge sys_rst) begin
      if (sys_rst) begin
         state      <= IDLE;
         grant      <= None;
         busy       <= 1'b0;
         last_grant <= 3'd4;
         deficit    <= '0;
      end else begin
         case (state)
            IDLE: begin
               for (int i = 0; i < 5; i++) begin
                  if (!enabled[i] || empty_v[i])
                     deficit[i] <= '0;
                  else if (pick == None)
                     deficit[i] <= refill(deficit[i],
                                          (i == 4) ? NicQuantum : Quantum);
               end
               if (pick != None) begin
                  grant <= pick;
                  busy  <= 1'b1;
                  state <= XFER;
               end
            end
            XFER: begin
               if (wr_en) begin
                  for (int i = 0; i < 5; i++)
                     if (grant == 3'(i) && deficit[i] != DefMin)
                        deficit[i] <= deficit[i] - 15'd1;
                  if (din[8]) begin
                     last_grant <= grant;
                     grant      <= None;
                     busy       <= 1'b0;
                     state      <= IDLE;
                  end
               end
            end
            default: state <= IDLE;
         endcase
      end
   end
endmodule

// File: tb/tb_drr_mixer.sv
// Self-checking bench for drr_mixer: FIFO models, per-source scoreboard,
// vector table for single frames and hand sequences for fairness/stall/reset.
module tb_drr_mixer;
   logic             sys_clk = 1'b0;
   logic             sys_rst = 1'b1;
   logic [8:0]       dv [5];
   logic             emp [5];
   logic             full;
   logic             port0_rd_en, port1_rd_en, port2_rd_en;
   logic             port3_rd_en, nic_rd_en;
   logic [8:0]       din;
   logic             wr_en;
   logic [2:0]       grant;
   logic             busy;
   logic [4:0][14:0] defs;

   drr_mixer dut (
      .sys_clk     (sys_clk),
      .sys_rst     (sys_rst),
      .port0_dout  (dv[0]),
      .port1_dout  (dv[1]),
      .port2_dout  (dv[2]),
      .port3_dout  (dv[3]),
      .nic_dout    (dv[4]),
      .port0_empty (emp[0]),
      .port1_empty (emp[1]),
      .port2_empty (emp[2]),
      .port3_empty (emp[3]),
      .nic_empty   (emp[4]),
      .port0_rd_en (port0_rd_en),
      .port1_rd_en (port1_rd_en),
      .port2_rd_en (port2_rd_en),
      .port3_rd_en (port3_rd_en),
      .nic_rd_en   (nic_rd_en),
      .din         (din),
      .full        (full),
      .wr_en       (wr_en),
      .grant       (grant),
      .busy        (busy)
   );

   assign defs = dut.deficit;

   always #4 sys_clk = ~sys_clk;

   typedef struct {
      int src;
      int len;
      int lat;
      int nwr;
      int def;
   } vec_t;

   vec_t       vecs [5];
   logic [8:0] src_q [5][$];
   logic [8:0] exp_q [5][$];
   int         load_len [5];
   int         fcnt [5];
   int         nbytes [5];
   int         nframes [5];
   logic       stall [5];
   int         log_g [$];
   bit         stall_on;
   int         cyc, first_busy, first_wr, last_wr, nwr, rd0_cnt;
   logic [4:0] rdv;
   int         nchk = 0;
   int         nerr = 0;

   task automatic chk(input string name, input int act, input int exp);
      nchk++;
      if (act != exp) begin
         nerr++;
         $display("FAIL %s: got %0d expected %0d (t=%0t)",
                  name, act, exp, $time);
      end
   endtask

   task automatic push_frame(input int s, input int len);
      logic [8:0] b;
      for (int k = 0; k < len; k++) begin
         b[7:0] = 8'(s * 50 + fcnt[s] * 7 + k);
         b[8]   = (k == len - 1);
         src_q[s].push_back(b);
         exp_q[s].push_back(b);
      end
      fcnt[s]++;
   endtask

   task automatic drive();
      for (int s = 0; s < 5; s++) begin
         emp[s] = (src_q[s].size() == 0) || stall[s];
         dv[s]  = (src_q[s].size() != 0) ? src_q[s][0] : 9'h000;
      end
   endtask

   task automatic feed();
      for (int s = 0; s < 5; s++)
         if (load_len[s] != 0 && src_q[s].size() < 200)
            push_frame(s, load_len[s]);
   endtask

   task automatic sample();
      logic       ew;
      logic [4:0] er;
      logic [8:0] e;
      rdv = {nic_rd_en, port3_rd_en, port2_rd_en, port1_rd_en, port0_rd_en};
      ew  = 1'b0;
      if (busy && grant <= 3'd4) ew = !full && !emp[grant];
      er = ew ? (5'd1 << grant) : 5'd0;
      chk("wr_en", wr_en, ew);
      chk("rd_en", rdv, er);
      if (rdv[0]) rd0_cnt++;
      if (busy && first_busy < 0) first_busy = cyc;
      if (wr_en) begin
         nwr++;
         if (first_wr < 0) first_wr = cyc;
         last_wr = cyc;
         if (grant > 3'd4) begin
            chk("wr_grant", grant, 4);
         end else if (exp_q[grant].size() == 0) begin
            chk("sb_extra_byte", exp_q[grant].size(), 1);
         end else begin
            e = exp_q[grant].pop_front();
            chk("din", din, e);
            nbytes[grant]++;
            if (din[8]) begin
               nframes[grant]++;
               log_g.push_back(int'(grant));
            end
         end
      end
   endtask

   task automatic tick();
      @(negedge sys_clk);
      cyc++;
      if (stall_on) begin
         if (cyc % 3 == 0) full = !full;
         for (int s = 0; s < 5; s++) stall[s] = ($urandom_range(0, 3) == 0);
      end
      drive();
      #1 sample();
      @(posedge sys_clk);
      #1;
      for (int s = 0; s < 5; s++)
         if (rdv[s] && src_q[s].size() > 0) void'(src_q[s].pop_front());
      feed();
      drive();
   endtask

   task automatic do_reset();
      sys_rst  = 1'b1;
      stall_on = 1'b0;
      full     = 1'b0;
      for (int s = 0; s < 5; s++) begin
         src_q[s].delete();
         exp_q[s].delete();
         load_len[s] = 0;
         fcnt[s]     = 0;
         nbytes[s]   = 0;
         nframes[s]  = 0;
         stall[s]    = 1'b0;
      end
      log_g.delete();
      drive();
      repeat (2) @(negedge sys_clk);
      sys_rst    = 1'b0;
      cyc        = 0;
      first_busy = -1;
      first_wr   = -1;
      last_wr    = -1;
      nwr        = 0;
      rd0_cnt    = 0;
   endtask

   initial begin
      int n;
      int d;
      int p1b;
      int p2b;
      int exp4 [28];

      vecs[0] = '{1, 64, 2, 64, 1454};
      vecs[1] = '{2, 1, 2, 1, 1517};
      vecs[2] = '{3, 1518, 2, 1518, 0};
      vecs[3] = '{4, 1600, 2, 1600, -82};
      vecs[4] = '{0, 10, -1, 0, 0};

      do_reset();
      chk("rst_grant", grant, 7);
      chk("rst_busy", busy, 0);
      chk("rst_wr_en", wr_en, 0);
      for (int s = 0; s < 5; s++) chk("rst_def", int'($signed(defs[s])), 0);

      // Single frames from a clean state; deficit read in the IDLE
      // cycle right after EOF, before an empty source gets cleared.
      foreach (vecs[v]) begin
         do_reset();
         push_frame(vecs[v].src, vecs[v].len);
         drive();
         n = 0;
         while (nframes[vecs[v].src] == 0 && n < vecs[v].len + 8) begin
            tick();
            n++;
         end
         chk("grant_latency", first_busy, vecs[v].lat);
         chk("bytes_written", nwr, vecs[v].nwr);
         if (vecs[v].nwr > 0)
            chk("burst_len", last_wr - first_wr + 1, vecs[v].nwr);
         chk("deficit_after", int'($signed(defs[vecs[v].src])), vecs[v].def);
         chk("grant_after_eof", grant, 7);
      end

      // Own port never granted, NIC frame still goes out.
      do_reset();
      push_frame(0, 30);
      push_frame(4, 40);
      drive();
      n = 0;
      while (nframes[4] == 0 && n < 200) begin tick(); n++; end
      repeat (5) tick();
      chk("own_port_bytes", nbytes[0], 0);
      chk("own_port_rd", rd0_cnt, 0);
      chk("nic_bytes", nbytes[4], 40);
      chk("own_port_left", exp_q[0].size(), 30);

      // Equal 100-byte load on 1,2,3,NIC: strict rotation.
      do_reset();
      for (int s = 1; s < 5; s++) load_len[s] = 100;
      feed();
      drive();
      n = 0;
      while (log_g.size() < 40 && n < 6000) begin tick(); n++; end
      chk("rr_done", int'(log_g.size() >= 40), 1);
      for (int i = 0; i < 40; i++) chk("rr_order", log_g[i], (i % 4) + 1);
      for (int s = 2; s < 5; s++) begin
         d = nbytes[s] - nbytes[1];
         if (d < 0) d = -d;
         chk("rr_bytes_balance", int'(d <= 100), 1);
      end

      // 1500-byte frames on port1 against 64-byte frames on port2.
      do_reset();
      load_len[1] = 1500;
      load_len[2] = 64;
      feed();
      drive();
      for (int i = 0; i < 28; i++) exp4[i] = 2;
      exp4[0]  = 1;
      exp4[2]  = 1;
      exp4[26] = 1;
      n = 0;
      while (nframes[1] < 14 && n < 45000) begin tick(); n++; end
      chk("drr_done", int'(nframes[1] >= 14), 1);
      for (int i = 0; i < 28; i++) chk("drr_order", log_g[i], exp4[i]);
      p1b = (nframes[1] - 1) * 1500;
      p2b = nframes[2] * 64;
      d   = p1b - p2b;
      if (d < 0) d = -d;
      chk("drr_share_10pct", int'(d * 10 <= p1b), 1);

      // Random backpressure and source underrun.
      do_reset();
      push_frame(1, 64);
      push_frame(4, 64);
      stall_on = 1'b1;
      drive();
      n = 0;
      while ((exp_q[1].size() != 0 || exp_q[4].size() != 0 || busy)
             && n < 3000) begin
         tick();
         n++;
      end
      chk("stall_done", int'(n < 3000), 1);
      chk("stall_bytes_p1", nbytes[1], 64);
      chk("stall_bytes_nic", nbytes[4], 64);
      chk("stall_writes", nwr, 128);

      // Asynchronous reset in the middle of a frame.
      do_reset();
      push_frame(1, 64);
      drive();
      n = 0;
      while (nbytes[1] < 20 && n < 200) begin tick(); n++; end
      chk("pre_rst_wr_en", wr_en, 1);
      #1 sys_rst = 1'b1;
      #1;
      chk("async_rst_wr_en", wr_en, 0);
      chk("async_rst_rd_en",
          {nic_rd_en, port3_rd_en, port2_rd_en, port1_rd_en, port0_rd_en}, 0);
      do_reset();
      chk("post_rst_grant", grant, 7);
      chk("post_rst_busy", busy, 0);
      for (int s = 0; s < 5; s++) chk("post_rst_def", int'($signed(defs[s])), 0);
      repeat (4) tick();
      chk("post_rst_idle", nwr, 0);

      $display("Simulation finished: %0d checks, %0d errors", nchk, nerr);
      $finish;
   end
endmodule
